// File: rtl/pll_phase_ctrl_if.sv
// Phase-request handshake between a controller (master) and the PLL phase sequencer (slave).
interface pll_phase_ctrl_if #(
  parameter int STEP_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_channel;
  logic              req_dir;
  logic [STEP_W-1:0] req_steps;

  modport master (
    output req_valid, req_channel, req_dir, req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_channel, req_dir, req_steps,
    output req_ready
  );
endinterface

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL dynamic-phase sequencer: drives PHASESEL/DIR/STEP/LOADREG for each request,
// waits for re-lock, and filters the raw PLL LOCK into `locked` with a lock-loss counter.
module pll_phase_ctrl #(
  parameter int NUM_CHANNELS = 4,
  parameter int STEP_W       = 8,
  parameter int SETUP_CYCLES = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int LOCK_FILTER  = 8,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int LOSS_W       = 8
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              pll_lock_raw,
  pll_phase_ctrl_if.slave   req,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  output logic              locked,
  output logic              done,
  output logic              err_timeout,
  output logic              err_range,
  output logic [LOSS_W-1:0] lock_loss_count
);

  localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
  localparam logic [2:0] NUM_CH_L = 3'(NUM_CHANNELS);

  typedef enum logic [2:0] {
    IDLE, SETUP, STEP_LO, STEP_HI, LOAD_LO, LOAD_HI, WAIT_LOCK
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [STEP_W-1:0]  remaining;
  logic [1:0]         lock_sync;
  logic [FILT_W-1:0]  filt_cnt;

  assign req.req_ready = (state == IDLE);

  // Lock filter: needs LOCK_FILTER consecutive synced-high cycles, drops on the first low one.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lock_sync       <= '0;
      filt_cnt        <= '0;
      locked          <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock_raw};
      if (!lock_sync[1]) begin
        filt_cnt <= '0;
        locked   <= 1'b0;
        if (locked && lock_loss_count != '1)
          lock_loss_count <= lock_loss_count + 1'b1;
      end else if (!locked) begin
        if (filt_cnt == FILT_W'(LOCK_FILTER - 1))
          locked <= 1'b1;
        else
          filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Request sequencer; pin outputs only change on state transitions so STEP edges never meet SEL/DIR changes.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      remaining    <= '0;
      phasesel     <= 2'd0;
      phasedir     <= 1'b0;
      phasestep    <= 1'b1;
      phaseloadreg <= 1'b1;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            if ({1'b0, req.req_channel} >= NUM_CH_L) begin
              err_range <= 1'b1;
            end else if (req.req_steps == '0) begin
              done <= 1'b1;
            end else begin
              phasesel  <= req.req_channel;
              phasedir  <= req.req_dir;
              remaining <= req.req_steps;
              cnt       <= '0;
              state     <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            cnt       <= '0;
            phasestep <= 1'b0;
            state     <= STEP_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STEP_LO: begin
          if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
            cnt       <= '0;
            phasestep <= 1'b1;
            remaining <= remaining - 1'b1;
            state     <= STEP_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STEP_HI: begin
          if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
            cnt <= '0;
            if (remaining != '0) begin
              phasestep <= 1'b0;
              state     <= STEP_LO;
            end else begin
              phaseloadreg <= 1'b0;
              state        <= LOAD_LO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD_LO: begin
          if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
            cnt          <= '0;
            phaseloadreg <= 1'b1;
            state        <= LOAD_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD_HI: begin
          if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= WAIT_LOCK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: directed vector table, random requests and lock-filter corner cases,
// all compared cycle by cycle against an arithmetic timeline model of each request.
module tb_pll_phase_ctrl;
  localparam int NUM_CH  = 3;
  localparam int STEP_W  = 8;
  localparam int SETUP   = 4;
  localparam int PULSE   = 2;
  localparam int FILT    = 8;
  localparam int TIMEOUT = 1000;
  localparam int LOSS_W  = 8;

  logic              clock_in = 1'b0;
  logic              reset;
  logic              pll_lock_raw;
  logic [1:0]        phasesel;
  logic              phasedir, phasestep, phaseloadreg, locked;
  logic              done, err_timeout, err_range;
  logic [LOSS_W-1:0] lock_loss_count;

  pll_phase_ctrl_if #(.STEP_W(STEP_W)) req_if ();

  pll_phase_ctrl #(
    .NUM_CHANNELS(NUM_CH), .STEP_W(STEP_W), .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE),
    .LOCK_FILTER(FILT), .LOCK_TIMEOUT(TIMEOUT), .LOSS_W(LOSS_W)
  ) dut (
    .clock_in(clock_in), .reset(reset), .pll_lock_raw(pll_lock_raw), .req(req_if),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .locked(locked), .done(done),
    .err_timeout(err_timeout), .err_range(err_range), .lock_loss_count(lock_loss_count)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int ch;
    int dir;
    int steps;
    int exp_outcome;
    int exp_pulses;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_sel  = 2'd0;
  logic       exp_dir  = 1'b0;
  vec_t       vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  function automatic logic [8:0] actual_vec();
    return {phasesel, phasedir, phasestep, phaseloadreg, req_if.req_ready, done, err_timeout, err_range};
  endfunction

  function automatic int t_end(input int ch, input int steps, input bit lock_ok);
    if (ch >= NUM_CH || steps == 0) return 1;
    return 1 + SETUP + steps * 2 * PULSE + 2 * PULSE + (lock_ok ? 1 : TIMEOUT);
  endfunction

  // Expected pins at cycle t after the accepting edge: outcome 0 = done after sequence, 1 = immediate done,
  // 2 = range error, 3 = timeout.
  function automatic logic [8:0] model_vec(input int t, input int ch, input int steps, input bit lock_ok,
                                           input logic [1:0] sel, input logic dir);
    int   u, te;
    logic st, ld, rdy, dn, et, er;
    st = 1'b1; ld = 1'b1; rdy = 1'b0; dn = 1'b0; et = 1'b0; er = 1'b0;
    if (ch >= NUM_CH) begin
      rdy = 1'b1;
      er  = (t == 1);
    end else if (steps == 0) begin
      rdy = 1'b1;
      dn  = (t == 1);
    end else begin
      u = t - 1 - SETUP;
      if (u >= 0 && u < steps * 2 * PULSE && (u % (2 * PULSE)) < PULSE) st = 1'b0;
      u = u - steps * 2 * PULSE;
      if (u >= 0 && u < PULSE) ld = 1'b0;
      te  = t_end(ch, steps, lock_ok);
      rdy = (t >= te);
      dn  = lock_ok && (t == te);
      et  = !lock_ok && (t == te);
    end
    return {sel, dir, st, ld, rdy, dn, et, er};
  endfunction

  task automatic run_request(input int ch, input int dir, input int steps, input bit lock_ok,
                             input string name, output int outcome, output int pulses);
    int         te;
    logic       prev_step;
    logic [8:0] exp;
    outcome   = 7;
    pulses    = 0;
    prev_step = 1'b1;
    req_if.req_valid   = 1'b1;
    req_if.req_channel = ch[1:0];
    req_if.req_dir     = dir[0];
    req_if.req_steps   = steps[STEP_W-1:0];
    tick();
    req_if.req_valid = 1'b0;
    if (ch < NUM_CH && steps > 0) begin
      exp_sel = ch[1:0];
      exp_dir = dir[0];
    end
    te = t_end(ch, steps, lock_ok);
    for (int t = 1; t <= te; t++) begin
      exp = model_vec(t, ch, steps, lock_ok, exp_sel, exp_dir);
      check($sformatf("%s t=%0d", name, t), 32'(actual_vec()), 32'(exp));
      if (!phasestep && prev_step) pulses++;
      prev_step = phasestep;
      if (outcome == 7) begin
        if (done) outcome = (t == 1) ? 1 : 0;
        else if (err_range) outcome = 2;
        else if (err_timeout) outcome = 3;
      end
      if (!lock_ok && t == 1 + SETUP + steps * 2 * PULSE) pll_lock_raw = 1'b0;
      if (t < te) tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_if.req_valid = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    exp_sel = 2'd0;
    exp_dir = 1'b0;
  endtask

  task automatic wait_locked(input string name);
    for (int i = 0; i < 40 && !locked; i++) tick();
    check(name, 32'(locked), 32'd1);
  endtask

  initial begin
    int   outcome, pulses, ch, dir, steps, exp_out;
    logic seen;

    vecs[0] = '{2, 1, 3, 0, 3};
    vecs[1] = '{0, 0, 0, 1, 0};
    vecs[2] = '{3, 1, 4, 2, 0};
    vecs[3] = '{1, 0, 1, 0, 1};
    vecs[4] = '{2, 0, 0, 1, 0};
    vecs[5] = '{0, 1, 5, 0, 5};
    vecs[6] = '{3, 0, 0, 2, 0};

    reset = 1'b1;
    pll_lock_raw = 1'b1;
    req_if.req_valid   = 1'b0;
    req_if.req_channel = 2'd0;
    req_if.req_dir     = 1'b0;
    req_if.req_steps   = '0;
    repeat (3) tick();
    check("reset pins", 32'({phasesel, phasedir, phasestep, phaseloadreg, locked, done, err_timeout, err_range}),
          32'(9'b00_0_1_1_0_0_0_0));
    check("reset loss count", 32'(lock_loss_count), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("lock filter k=%0d", k), 32'(locked), 32'(k >= 2 + FILT));
    end
    check("ready after reset", 32'(req_if.req_ready), 32'd1);

    foreach (vecs[i]) begin
      run_request(vecs[i].ch, vecs[i].dir, vecs[i].steps, 1'b1, $sformatf("vec%0d", i), outcome, pulses);
      check($sformatf("vec%0d outcome", i), 32'(outcome), 32'(vecs[i].exp_outcome));
      check($sformatf("vec%0d pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
    end

    for (int i = 0; i < 16; i++) begin
      ch    = int'($urandom_range(0, 3));
      dir   = int'($urandom_range(0, 1));
      steps = int'($urandom_range(0, 5));
      exp_out = (ch >= NUM_CH) ? 2 : (steps == 0) ? 1 : 0;
      run_request(ch, dir, steps, 1'b1, $sformatf("rnd%0d", i), outcome, pulses);
      check($sformatf("rnd%0d outcome", i), 32'(outcome), 32'(exp_out));
      check($sformatf("rnd%0d pulses", i), 32'(pulses), 32'((exp_out == 0) ? steps : 0));
    end

    // Re-lock never arrives: timeout after the full wait, and exactly one lock loss recorded.
    do_reset();
    wait_locked("lock before timeout");
    run_request(1, 0, 2, 1'b0, "timeout", outcome, pulses);
    check("timeout outcome", 32'(outcome), 32'd3);
    check("timeout loss count", 32'(lock_loss_count), 32'd1);
    pll_lock_raw = 1'b1;
    wait_locked("relock after timeout");

    pll_lock_raw = 1'b0;
    repeat (4) tick();
    check("lock drop", 32'(locked), 32'd0);
    seen = 1'b0;
    pll_lock_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) pll_lock_raw = 1'b0;
      tick();
      seen = seen | locked;
    end
    check("glitch no lock", 32'(seen), 32'd0);

    pll_lock_raw = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      pll_lock_raw = 1'b1;
      repeat (12) tick();
      if (i == 0) check("toggle locked rises", 32'(locked), 32'd1);
      pll_lock_raw = 1'b0;
      repeat (4) tick();
      if (i == 99) check("loss count 100", 32'(lock_loss_count), 32'd100);
    end
    check("loss count saturates", 32'(lock_loss_count), 32'd255);

    // Reset lands in the middle of a long step burst; the next request must run from scratch.
    pll_lock_raw = 1'b1;
    do_reset();
    wait_locked("lock before long burst");
    req_if.req_valid   = 1'b1;
    req_if.req_channel = 2'd1;
    req_if.req_dir     = 1'b1;
    req_if.req_steps   = 8'd200;
    tick();
    req_if.req_valid = 1'b0;
    for (int i = 0; i < 20 && phasestep; i++) tick();
    check("reach step low", 32'(phasestep), 32'd0);
    reset = 1'b1;
    #1;
    check("async reset pins", 32'({phasestep, phaseloadreg, phasesel, phasedir}), 32'(5'b1_1_00_0));
    tick();
    reset   = 1'b0;
    exp_sel = 2'd0;
    exp_dir = 1'b0;
    wait_locked("lock after mid reset");
    run_request(1, 1, 200, 1'b1, "long", outcome, pulses);
    check("long outcome", 32'(outcome), 32'd0);
    check("long pulses", 32'(pulses), 32'd200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
